// File: rtl/signal_reduction_pkg.sv
// rtl/signal_reduction_pkg.sv - shared widths and saturation encoding for signal_reduction
package signal_reduction_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 11;
    localparam int DEF_SHIFT = 0;
    localparam int CNT_W     = 8;

    // Bit 1 flags high saturation, bit 0 flags low saturation.
    typedef enum logic [1:0] {
        NONE = 2'b00,
        LOW  = 2'b01,
        HIGH = 2'b10
    } sat_e;

endpackage

// File: rtl/signal_reduction_sat_counter.sv
// rtl/signal_reduction_sat_counter.sv - up counter that holds at all-ones, with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/signal_reduction.sv
// rtl/signal_reduction.sv - two-stage shift/saturate narrowing pipeline with overflow tracking
// Define SIGNAL_REDUCTION_ROUND_EN to round half up before the shift instead of truncating.
module signal_reduction
    import signal_reduction_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [IN_W-1:0]  Input,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [OUT_W-1:0] Output,
    output logic [1:0]       Sat,
    output logic             Sticky_Ovf,
    output logic [CNT_W-1:0] Ovf_Count,
    input  logic             Clear
);

    localparam int EW = IN_W + 1;
    localparam logic signed [EW-1:0] MAX_V = EW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] shifted;
    sat_e                 cls;

    logic                 s1_valid;
    logic [OUT_W-1:0]     s1_word;
    sat_e                 s1_sat;
    logic                 s2_accept;
    logic                 sat_xfer;

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
`ifdef SIGNAL_REDUCTION_ROUND_EN
    localparam logic signed [EW-1:0] RND = EW'((1 << SHIFT) >> 1);
    assign ext = $signed({Input[IN_W-1], Input}) + RND;
`else
    assign ext = $signed({Input[IN_W-1], Input});
`endif

    assign shifted = ext >>> SHIFT;

    always_comb begin
        cls = NONE;
        if (shifted > MAX_V) begin
            cls = HIGH;
        end else if (shifted < MIN_V) begin
            cls = LOW;
        end
    end

    assign s2_accept = !Out_Valid || Out_Ready;
    assign In_Ready  = !s1_valid || s2_accept;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
            s1_sat   <= NONE;
        end else if (In_Ready) begin
            s1_valid <= In_Valid;
            if (In_Valid) begin
                s1_word <= shifted[OUT_W-1:0];
                s1_sat  <= cls;
            end
        end
    end

    // Output and Sat only move when the consumer can take a new word.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Out_Valid <= 1'b0;
            Output    <= '0;
            Sat       <= NONE;
        end else if (s2_accept) begin
            Out_Valid <= s1_valid;
            if (s1_valid) begin
                Sat <= s1_sat;
                case (s1_sat)
                    HIGH:    Output <= MAX_V[OUT_W-1:0];
                    LOW:     Output <= MIN_V[OUT_W-1:0];
                    default: Output <= s1_word;
                endcase
            end
        end
    end

    assign sat_xfer = Out_Valid && Out_Ready && (Sat != NONE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Sticky_Ovf <= 1'b0;
        end else if (Clear) begin
            Sticky_Ovf <= 1'b0;
        end else if (sat_xfer) begin
            Sticky_Ovf <= 1'b1;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_ovf_count (
        .clk   (Clk),
        .rst_n (Reset_n),
        .inc   (sat_xfer),
        .clear (Clear),
        .count (Ovf_Count)
    );

endmodule

// File: doc/signal_reduction.md
SIGNAL_REDUCTION -- requirements
Module: signal_reduction

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning the signed input word width.
REQ-002 SHALL have parameter OUT_W, default 11, meaning the signed output word width; OUT_W < IN_W.
REQ-003 SHALL have parameter SHIFT, default 0, meaning the arithmetic right shift applied before narrowing; 0 <= SHIFT < IN_W-OUT_W+1.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port In_Valid, input, 1 bit: Input holds a valid word.
REQ-007 SHALL have port In_Ready, output, 1 bit: block accepts Input this cycle.
REQ-008 SHALL have port Input, input, IN_W bits: signed two's-complement word.
REQ-009 SHALL have port Out_Valid, output, 1 bit: Output holds a valid word.
REQ-010 SHALL have port Out_Ready, input, 1 bit: consumer accepts Output this cycle.
REQ-011 SHALL have port Output, output, OUT_W bits: saturated, narrowed signed word.
REQ-012 SHALL have port Sat, output, 2 bits: {high-saturated, low-saturated} flags aligned with Output.
REQ-013 SHALL have port Sticky_Ovf, output, 1 bit: set on any saturation since last clear.
REQ-014 SHALL have port Ovf_Count, output, 8 bits: saturating count of saturated words delivered.
REQ-015 SHALL have port Clear, input, 1 bit: synchronous clear of Sticky_Ovf and Ovf_Count.

Function
REQ-016 SHALL transfer on input when In_Valid && In_Ready, on output when Out_Valid && Out_Ready.
REQ-017 SHALL implement two pipeline stages: S1 registers the shifted value and range-compare result; S2 registers Output, Sat, Out_Valid.
REQ-018 SHALL deliver a word accepted in cycle N on Output in cycle N+2 when Out_Ready is held high (latency 2, throughput 1/cycle).
REQ-019 SHALL stall a stage only if it is valid and the next stage cannot accept; In_Ready = !S1_valid || S2 can accept, where S2 can accept = !Out_Valid || Out_Ready.
REQ-020 SHALL hold Output and Sat stable while Out_Valid && !Out_Ready; no word is dropped or duplicated.
REQ-021 SHALL compute v = Input >>> SHIFT (arithmetic, sign-preserving).
REQ-022 SHALL output v unchanged in OUT_W bits when -2^(OUT_W-1) <= v <= 2^(OUT_W-1)-1, Sat=00.
REQ-023 SHALL output 2^(OUT_W-1)-1 with Sat=10 when v is above range, and -2^(OUT_W-1) with Sat=01 when below.
REQ-024 SHALL set Sticky_Ovf and increment Ovf_Count (holding at 255) on each output transfer with Sat != 00.
REQ-025 SHALL give Clear priority over a simultaneous increment: counter and sticky go to 0 that cycle.
REQ-026 SHALL not affect the data path when Clear is asserted.

Reset
REQ-027 SHALL on Reset_n low immediately force Out_Valid=0, S1_valid=0, Output=0, Sat=00, Sticky_Ovf=0, Ovf_Count=0, In_Ready=1 once released.
REQ-028 SHALL discard any in-flight words when reset is asserted mid-operation; first accepted word after release emerges at latency 2.

Configuration
REQ-029 SHALL, with SIGNAL_REDUCTION_ROUND_EN defined and SHIFT>0, add 2^(SHIFT-1) to Input (IN_W+1-bit signed arithmetic, no wrap) before the shift (round half up).
REQ-030 SHALL, without SIGNAL_REDUCTION_ROUND_EN, truncate (floor) with no rounding adder present.

Structure
REQ-031 SHALL place default widths, counter width, and the Sat encoding typedef (NONE, LOW, HIGH) in package signal_reduction_pkg.
REQ-032 SHALL implement the overflow counter as sub-module sat_counter (width parameter, inc, clear, saturate at max).

Verification
REQ-033 SHALL cover: defaults, Input=0x03FF -> Output=0x3FF, Sat=00 after 2 cycles.
REQ-034 SHALL cover: Input=0x0400 -> Output=0x3FF, Sat=10; Input=0xFBFF -> Output=0x400, Sat=01; Sticky_Ovf=1, Ovf_Count=2.
REQ-035 SHALL cover: stream 0x0001..0x0008 with Out_Ready low cycles 3-5 -> all 8 words in order, In_Ready low while both stages full.
REQ-036 SHALL cover: 300 saturating words -> Ovf_Count=255; Clear asserted with a saturating transfer -> 0.
REQ-037 SHALL cover: Reset_n low with 2 words in flight -> Out_Valid=0 immediately, no stale word after release.
REQ-038 SHALL cover: SHIFT=2 with ROUND_EN, Input=0x0006 -> Output=0x002; without it -> 0x001.
